// File: rtl/kf76489_pkg.sv
// Shared types, register codes and write-decode helper for the KF76489 CPU write path.
package kf76489_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_COMMIT,
    ST_RELEASE
  } state_e;

  // Register codes as {R0,R1,R2}; R0 is the MSB.
  localparam logic [2:0] REG_TONE0_FREQ = 3'b000;
  localparam logic [2:0] REG_TONE0_ATTN = 3'b001;
  localparam logic [2:0] REG_TONE1_FREQ = 3'b010;
  localparam logic [2:0] REG_TONE1_ATTN = 3'b011;
  localparam logic [2:0] REG_TONE2_FREQ = 3'b100;
  localparam logic [2:0] REG_TONE2_ATTN = 3'b101;
  localparam logic [2:0] REG_NOISE_CTRL = 3'b110;
  localparam logic [2:0] REG_NOISE_ATTN = 3'b111;

  localparam int LATCH_BIT = 0;

  typedef struct packed {
    logic [2:0] tone_freq_latch;
    logic [2:0] tone_freq_data;
    logic [2:0] tone_attn;
    logic       noise_ctrl;
    logic       noise_attn;
  } strobes_t;

  // Pins use TI numbering, so D1..D3 carry R0..R2 in reverse of vector order.
  function automatic logic [2:0] latch_reg(input logic [7:0] b);
    return {b[1], b[2], b[3]};
  endfunction

  function automatic logic [2:0] target_reg(input logic [7:0] b, input logic [2:0] last_reg);
    return b[LATCH_BIT] ? latch_reg(b) : last_reg;
  endfunction

  function automatic strobes_t decode_write(input logic [7:0] b, input logic [2:0] last_reg);
    strobes_t   s;
    logic [2:0] target;
    logic [1:0] tone;
    s      = '0;
    target = target_reg(b, last_reg);
    tone   = target[2:1];
    case (target)
      REG_NOISE_CTRL: s.noise_ctrl = 1'b1;
      REG_NOISE_ATTN: s.noise_attn = 1'b1;
      REG_TONE0_ATTN, REG_TONE1_ATTN, REG_TONE2_ATTN: s.tone_attn = 3'b001 << tone;
      default: begin
        if (b[LATCH_BIT]) s.tone_freq_latch = 3'b001 << tone;
        else              s.tone_freq_data  = 3'b001 << tone;
      end
    endcase
    return s;
  endfunction

endpackage

// File: rtl/kf76489_bus_synchronizer.sv
// Two-flop synchronizer for the asynchronous /CE and /WE pins; flags a bus write request.
module kf76489_bus_synchronizer (
  input  logic clock,
  input  logic reset,
  input  logic chip_select_n,
  input  logic write_enable_n,
  output logic sync_write
);

  logic [1:0] ce_sync_q;
  logic [1:0] we_sync_q;

  // NOTE: synchronizer flops reset to the idle-high pin level so no phantom write appears after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ce_sync_q <= 2'b11;
      we_sync_q <= 2'b11;
    end else begin
      ce_sync_q <= {ce_sync_q[0], chip_select_n};
      we_sync_q <= {we_sync_q[0], write_enable_n};
    end
  end

  assign sync_write = ~ce_sync_q[1] & ~we_sync_q[1];

endmodule

// File: rtl/kf76489_write_sequencer.sv
// CPU write controller for the KF76489: READY wait, latch/data decode, per-register strobes
// and the shared clock_enable prescaler.
module kf76489_write_sequencer
  import kf76489_pkg::*;
#(
  parameter int CLOCK_DIV   = 4,
  parameter int WAIT_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus_in,
  output logic       ready,
  output logic       clock_enable,
  output logic [7:0] internal_data_bus,
  output logic [2:0] write_tone_frequency_latch,
  output logic [2:0] write_tone_frequency_data,
  output logic [2:0] write_tone_attenuation,
  output logic       write_noise_control,
  output logic       write_noise_attenuation
);

  localparam int PW = $clog2(CLOCK_DIV);
  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESCALE_RELOAD = PW'(CLOCK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST       = WW'(WAIT_CYCLES - 1);

  logic sync_write;

  kf76489_bus_synchronizer u_sync (
    .clock          (clock),
    .reset          (reset),
    .chip_select_n  (chip_select_n),
    .write_enable_n (write_enable_n),
    .sync_write     (sync_write)
  );

  // Prescaler: free-running down-counter, pulse while at zero.
  logic [PW-1:0] prescale_q, prescale_d;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    prescale_d = prescale_q - 1'b1;
    if (prescale_q == '0) prescale_d = PRESCALE_RELOAD;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) prescale_q <= PRESCALE_RELOAD;
    else       prescale_q <= prescale_d;
  end

  assign clock_enable = (prescale_q == '0);

  // Write FSM with registered ready, data and strobe outputs.
  state_e        state_q;
  logic [WW-1:0] wait_cnt_q;
  logic [7:0]    data_q;
  logic [2:0]    last_reg_q;
  logic          ready_q;
  strobes_t      strobes_q;
  strobes_t      strobes_d;
  logic [2:0]    last_reg_d;

  always_comb begin
    strobes_d  = decode_write(data_q, last_reg_q);
    last_reg_d = target_reg(data_q, last_reg_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      data_q     <= 8'h00;
      last_reg_q <= REG_TONE0_FREQ;
      ready_q    <= 1'b1;
      strobes_q  <= '0;
    end else begin
      strobes_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (sync_write) begin
            data_q     <= data_bus_in;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Pin activity is ignored here: once accepted, a write always completes.
          if (wait_cnt_q == WAIT_LAST) begin
            strobes_q  <= strobes_d;
            last_reg_q <= last_reg_d;
            state_q    <= ST_COMMIT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          ready_q <= 1'b1;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!sync_write) state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready                      = ready_q;
  assign internal_data_bus          = data_q;
  assign write_tone_frequency_latch = strobes_q.tone_freq_latch;
  assign write_tone_frequency_data  = strobes_q.tone_freq_data;
  assign write_tone_attenuation     = strobes_q.tone_attn;
  assign write_noise_control        = strobes_q.noise_ctrl;
  assign write_noise_attenuation    = strobes_q.noise_attn;

endmodule

// File: tb/tb_kf76489_write_sequencer.sv
// Directed bench for kf76489_write_sequencer: prescaler, write table, held /WE and mid-wait reset.
module tb_kf76489_write_sequencer;

  localparam int CLOCK_DIV   = 4;
  localparam int WAIT_CYCLES = 32;
  localparam int LOW_CYCLES  = WAIT_CYCLES + 1;

  // Strobe vector: {freq_latch[2:0], freq_data[2:0], attn[2:0], noise_ctrl, noise_attn}
  localparam logic [10:0] FL0 = 11'h100, FL1 = 11'h200, FL2 = 11'h400;
  localparam logic [10:0] FD0 = 11'h020, FD1 = 11'h040, FD2 = 11'h080;
  localparam logic [10:0] AT0 = 11'h004, AT1 = 11'h008, AT2 = 11'h010;
  localparam logic [10:0] NC  = 11'h002, NA  = 11'h001;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       chip_select_n = 1'b1;
  logic       write_enable_n = 1'b1;
  logic [7:0] data_bus_in = 8'h00;
  logic       ready;
  logic       clock_enable;
  logic [7:0] internal_data_bus;
  logic [2:0] write_tone_frequency_latch;
  logic [2:0] write_tone_frequency_data;
  logic [2:0] write_tone_attenuation;
  logic       write_noise_control;
  logic       write_noise_attenuation;

  kf76489_write_sequencer #(
    .CLOCK_DIV   (CLOCK_DIV),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .chip_select_n              (chip_select_n),
    .write_enable_n             (write_enable_n),
    .data_bus_in                (data_bus_in),
    .ready                      (ready),
    .clock_enable               (clock_enable),
    .internal_data_bus          (internal_data_bus),
    .write_tone_frequency_latch (write_tone_frequency_latch),
    .write_tone_frequency_data  (write_tone_frequency_data),
    .write_tone_attenuation     (write_tone_attenuation),
    .write_noise_control        (write_noise_control),
    .write_noise_attenuation    (write_noise_attenuation)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] strobes();
    return {write_tone_frequency_latch, write_tone_frequency_data, write_tone_attenuation,
            write_noise_control, write_noise_attenuation};
  endfunction

  // Drive one bus write, hold /WE low for 'hold' cycles, and watch until READY has cycled.
  task automatic do_write(input logic [7:0] d, input int hold,
                          output int low_cnt, output int strobe_cnt, output logic [10:0] strobe_seen,
                          output int strobe_pos, output logic [7:0] idb_at_strobe,
                          output logic timed_out);
    int   i;
    logic low_done;
    low_cnt = 0; strobe_cnt = 0; strobe_seen = '0; strobe_pos = -1;
    idb_at_strobe = '0; timed_out = 1'b0; low_done = 1'b0; i = 0;
    @(negedge clock);
    data_bus_in = d; chip_select_n = 1'b0; write_enable_n = 1'b0;
    while (1) begin
      @(negedge clock);
      i++;
      if (!ready) low_cnt++;
      else if (low_cnt > 0) low_done = 1'b1;
      if (strobes() != '0) begin
        strobe_cnt++;
        strobe_seen   = strobe_seen | strobes();
        strobe_pos    = low_cnt;
        idb_at_strobe = internal_data_bus;
      end
      if (i == hold) begin chip_select_n = 1'b1; write_enable_n = 1'b1; end
      if (i >= hold + 4 && low_done) break;
      if (i > 400) begin
        timed_out = 1'b1; chip_select_n = 1'b1; write_enable_n = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    int          hold;
    logic [10:0] exp_strobe;
    string       name;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input vec_t v);
    int          low_cnt, strobe_cnt, strobe_pos;
    logic [10:0] seen;
    logic [7:0]  idb;
    logic        to;
    do_write(v.data, v.hold, low_cnt, strobe_cnt, seen, strobe_pos, idb, to);
    check({v.name, "_timeout"}, to, 1'b0);
    check({v.name, "_ready_low_cycles"}, low_cnt, LOW_CYCLES);
    check({v.name, "_strobe_count"}, strobe_cnt, 1);
    check({v.name, "_strobe"}, seen, v.exp_strobe);
    check({v.name, "_strobe_in_last_low"}, strobe_pos, LOW_CYCLES);
    check({v.name, "_idb_at_strobe"}, idb, v.data);
    check({v.name, "_idb_held"}, internal_data_bus, v.data);
  endtask

  initial begin
    logic [10:0] seen;
    vecs[0]  = '{8'h0F,   5, NA,  "latch_noise_attn"};
    vecs[1]  = '{8'h05,   5, FL1, "latch_tone1_freq"};
    vecs[2]  = '{8'hAA,   5, FD1, "data_tone1_freq"};
    vecs[3]  = '{8'hA7,   5, NC,  "latch_noise_ctrl"};
    vecs[4]  = '{8'h5A,   5, NC,  "data_noise_ctrl"};
    vecs[5]  = '{8'h0B,   5, AT2, "latch_tone2_attn"};
    vecs[6]  = '{8'h44, 100, AT2, "data_tone2_attn_held"};
    vecs[7]  = '{8'h01,   5, FL0, "latch_tone0_freq"};
    vecs[8]  = '{8'h3C,   5, FD0, "data_tone0_freq"};
    vecs[9]  = '{8'h0D,   5, AT1, "latch_tone1_attn"};
    vecs[10] = '{8'h03,   5, FL2, "latch_tone2_freq"};
    vecs[11] = '{8'hF0,   5, FD2, "data_tone2_freq"};
    vecs[12] = '{8'h09,   5, AT0, "latch_tone0_attn"};
    vecs[13] = '{8'h52,   5, AT0, "data_tone0_attn"};

    // Reset state and prescaler cadence
    repeat (3) @(negedge clock);
    check("rst_ready", ready, 1'b1);
    check("rst_strobes", strobes(), 11'h000);
    check("rst_idb", internal_data_bus, 8'h00);
    check("rst_clock_enable", clock_enable, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      check($sformatf("clock_enable_%0d", k), clock_enable, (k % CLOCK_DIV) == CLOCK_DIV - 1);
      check($sformatf("idle_ready_%0d", k), ready, 1'b1);
    end
    check("idle_strobes", strobes(), 11'h000);

    // Write table; entry 6 holds /WE low for 100 clocks
    for (int v = 0; v < 14; v++) run_vec(vecs[v]);

    // Reset 10 clocks into WAIT aborts the write and returns last_reg to tone 0 frequency
    @(negedge clock);
    data_bus_in = 8'h05; chip_select_n = 1'b0; write_enable_n = 1'b0;
    for (int k = 0; k < 10 && ready; k++) @(negedge clock);
    check("abort_accepted", ready, 1'b0);
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      seen = seen | strobes();
    end
    check("abort_no_strobe_before_reset", seen, 11'h000);
    reset = 1'b1;
    #1;
    check("abort_ready_immediate", ready, 1'b1);
    check("abort_idb_cleared", internal_data_bus, 8'h00);
    chip_select_n = 1'b1; write_enable_n = 1'b1;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      seen = seen | strobes();
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      seen = seen | strobes();
      check($sformatf("abort_ready_%0d", k), ready, 1'b1);
    end
    check("abort_no_strobe", seen, 11'h000);
    run_vec('{8'hAA, 5, FD0, "post_reset_data_tone0"});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
